tenbaset_tx_ctrl: RTL and testbench
===================================

TENBASET_TX_CTRL -- requirements
Module: tenbaset_tx_ctrl

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 192: clk20 cycles of inter-frame gap (9.6 us).
REQ-002 SHALL have parameter MIN_LEN, default 68: minimum RAM bytes per frame (8 preamble/SFD plus 60 payload).
REQ-003 SHALL have parameter MAX_LEN, default 1522: maximum RAM bytes per frame.
REQ-004 SHALL have port clk20 input 1: 20 MHz clock, sole clock.
REQ-005 SHALL have port rst_n input 1: reset, asynchronous, active-low.
REQ-006 SHALL have ports req0, req1 input 1 each: transmit request, level, held until matching done.
REQ-007 SHALL have ports len0, len1 input 11 each: frame byte count in RAM (preamble/SFD included, CRC excluded).
REQ-008 SHALL have ports done0, done1 output 1 each: one-cycle completion pulse.
REQ-009 SHALL have port err output 1: one-cycle pulse when a length is rejected, coincident with done.
REQ-010 SHALL have port buf_sel output 1: selects requester's packet RAM; valid throughout SEND and FLUSH.
REQ-011 SHALL have port SendingPacket output 1: transmitter enable.
REQ-012 SHALL have ports CRCflush output 1 and CRC output 1: CRC serialisation to transmitter.
REQ-013 SHALL have ports ShiftCount input 4 and tx_bit input 1: transmitter phase counter and current serial data bit.
REQ-014 SHALL have port busy output 1: high in any state except IDLE.

Function
REQ-015 SHALL implement states IDLE, SEND, FLUSH, IFG.
REQ-016 IDLE: on any req high, SHALL latch winner into buf_sel and winner's len, enter SEND next edge; SendingPacket SHALL rise on that same edge.
REQ-017 Latched len < MIN_LEN SHALL be padded to MIN_LEN (padding bytes read from RAM as-is).
REQ-018 Latched len > MAX_LEN SHALL not be sent: stay IDLE, pulse err and done of that requester one cycle after grant.
REQ-019 SEND SHALL last exactly len*16 cycles, then FLUSH for exactly 64 cycles; SendingPacket high through both.
REQ-020 CRCflush SHALL be high exactly during FLUSH.
REQ-021 CRC-32 (poly 0x04C11DB7, init all-ones, LSB-first) SHALL update once per bit on edges with ShiftCount[0]==1, using tx_bit, only for bytes 8..len-1 of SEND.
REQ-022 FLUSH SHALL output CRC = inverted MSB of CRC register and shift register left one place per bit (ShiftCount[0]==1 edges), emitting 32 bits.
REQ-023 At FLUSH end, SendingPacket SHALL fall, granted requester's done pulses one cycle, state enters IFG.
REQ-024 IFG SHALL last IFG_CYCLES cycles, then IDLE; requests during IFG SHALL wait.
REQ-025 Arbitration SHALL be round-robin: on simultaneous requests, requester not served last wins; after reset requester 0 wins ties.
REQ-026 Deassertion of req mid-frame SHALL be ignored; frame completes and done still pulses.
REQ-027 len inputs SHALL be sampled only at grant; later changes SHALL not affect current frame.
REQ-028 Byte counter SHALL be 11 bits, cycle counter 4 bits, IFG counter ceil(log2(IFG_CYCLES+1)) bits; no wrap inside a frame.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, SendingPacket=0, CRCflush=0, CRC=0, done0=done1=err=0, buf_sel=0, busy=0, round-robin pointer to requester 0.
REQ-030 Reset mid-frame SHALL abort without done; after release, the first request SHALL still observe full IFG only if issued before IFG_CYCLES elapsed (IFG counter preset to IFG_CYCLES on reset).

Configuration
REQ-031 With TENBASET_TX_FIXED_PRIO_EN defined, requester 0 SHALL always win simultaneous requests; without it, REQ-025 round-robin applies.

Verification
REQ-032 req0 with len0=68 -> SendingPacket high 1152 cycles, CRCflush high final 64, done0 pulse at fall, busy low 192 cycles later.
REQ-033 Frame of 60 bytes 0x00 after standard preamble/SFD -> 32 serialised CRC bits equal 0x4E3B_6C52 byte-reversed per Ethernet FCS (check against software model).
REQ-034 req0 and req1 raised same cycle, both held, repeated -> grants 0,1,0,1; with TENBASET_TX_FIXED_PRIO_EN grants 0,0,0.
REQ-035 len1=1600 -> no SendingPacket, err and done1 pulse together, state IDLE.
REQ-036 rst_n low at cycle 500 of SEND -> SendingPacket low immediately, no done; req0 still high after release -> new frame starts only after 192 cycles.
REQ-037 len0=20 -> frame padded, SendingPacket high (68+4)*16=1152 cycles.

Source files
------------

// File: rtl/tenbaset_tx_ctrl_if.sv
// Request/completion bundle between the two packet-RAM owners and
// the 10BASE-T transmit controller.
//   req0/req1 : transmit request levels, held until the matching done
//   len0/len1 : frame byte count in RAM (preamble/SFD in, CRC out)
//   done0/1   : one-cycle completion pulses
//   err       : one-cycle length-reject pulse, coincident with done
interface tenbaset_tx_ctrl_if;
  logic        req0;
  logic        req1;
  logic [10:0] len0;
  logic [10:0] len1;
  logic        done0;
  logic        done1;
  logic        err;

  modport master (
    output req0, req1, len0, len1,
    input  done0, done1, err
  );

  modport slave (
    input  req0, req1, len0, len1,
    output done0, done1, err
  );
endinterface

// File: rtl/tenbaset_tx_ctrl.sv
// 10BASE-T transmit controller: arbitrates two packet RAMs, times the
// frame (SEND), serialises the Ethernet FCS (FLUSH), enforces the IFG.
// Ports: clk20, rst_n (async, active-low), bus (req/len/done/err),
//   ShiftCount/tx_bit from the transmitter, buf_sel, SendingPacket,
//   CRCflush, CRC and busy outputs.
// Config: define TENBASET_TX_FIXED_PRIO_EN for fixed priority to
//   requester 0; default build uses round-robin arbitration.
module tenbaset_tx_ctrl #(
  parameter int IFG_CYCLES = 192,
  parameter int MIN_LEN    = 68,
  parameter int MAX_LEN    = 1522
) (
  input  logic                     clk20,
  input  logic                     rst_n,
  tenbaset_tx_ctrl_if.slave        bus,
  input  logic [3:0]               ShiftCount,
  input  logic                     tx_bit,
  output logic                     buf_sel,
  output logic                     SendingPacket,
  output logic                     CRCflush,
  output logic                     CRC,
  output logic                     busy
);

  localparam int IFGW = $clog2(IFG_CYCLES + 1);
  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);
  localparam logic [IFGW-1:0] IFG_L = IFGW'(IFG_CYCLES);
  localparam logic [IFGW-1:0] IFG_1 = IFGW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    FLUSH,
    IFG
  } state_e;

  state_e          state_q, state_d;
  logic [10:0]     len_q, len_d;
  logic [10:0]     byte_q, byte_d;
  logic [3:0]      cyc_q, cyc_d;
  logic [IFGW-1:0] ifg_q, ifg_d;
  logic [31:0]     crc_q, crc_d;
  logic            rr_q, rr_d;
  logic            sel_q, sel_d;
  logic            sp_q, sp_d;
  logic            fl_q, fl_d;
  logic            busy_q, busy_d;
  logic            done0_q, done0_d;
  logic            done1_q, done1_d;
  logic            err_q, err_d;

  logic        win;
  logic        pend;
  logic        hold;
  logic        last_cyc;
  logic [10:0] len_sel;
  logic [31:0] crc_upd;
  logic        unused_sc;

  assign unused_sc = ^ShiftCount[3:1];

`ifdef TENBASET_TX_FIXED_PRIO_EN
  logic unused_rr;
  assign unused_rr = rr_q;
  assign win = ~bus.req0;
`else
  // rr_q names the requester that wins a tie
  assign win = (bus.req0 & bus.req1) ? rr_q : bus.req1;
`endif

  assign pend     = bus.req0 | bus.req1;
  assign len_sel  = win ? bus.len1 : bus.len0;
  assign last_cyc = (cyc_q == 4'd15);

  // A rejected requester may still hold req while its done is high;
  // never regrant in that cycle.
  assign hold = done0_q | done1_q;

  // Non-reflected register fed LSB-first: equivalent to Ethernet CRC.
  assign crc_upd = {crc_q[30:0], 1'b0}
                 ^ (POLY & {32{crc_q[31] ^ tx_bit}});

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    byte_d  = byte_q;
    cyc_d   = cyc_q;
    ifg_d   = ifg_q;
    crc_d   = crc_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    sp_d    = sp_q;
    fl_d    = fl_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A gap left over from reset still has to expire first
        if (ifg_q != '0) begin
          ifg_d = ifg_q - IFG_1;
        end else if (pend && !hold) begin
          rr_d = ~win;
          if (len_sel > MAX_L) begin
            err_d   = 1'b1;
            done0_d = ~win;
            done1_d = win;
          end else begin
            state_d = SEND;
            sel_d   = win;
            len_d   = (len_sel < MIN_L) ? MIN_L : len_sel;
            byte_d  = '0;
            cyc_d   = '0;
            crc_d   = '1;
            sp_d    = 1'b1;
          end
        end
      end
      SEND: begin
        cyc_d = cyc_q + 4'd1;
        if (ShiftCount[0] && byte_q >= 11'd8) begin
          crc_d = crc_upd;
        end
        if (last_cyc) begin
          if (byte_q == len_q - 11'd1) begin
            state_d = FLUSH;
            fl_d    = 1'b1;
            byte_d  = '0;
          end else begin
            byte_d = byte_q + 11'd1;
          end
        end
      end
      FLUSH: begin
        // byte_q counts the four FCS bytes here
        cyc_d = cyc_q + 4'd1;
        if (ShiftCount[0]) begin
          crc_d = {crc_q[30:0], 1'b0};
        end
        if (last_cyc) begin
          if (byte_q == 11'd3) begin
            state_d = IFG;
            sp_d    = 1'b0;
            fl_d    = 1'b0;
            done0_d = ~sel_q;
            done1_d = sel_q;
            ifg_d   = IFG_L;
          end else begin
            byte_d = byte_q + 11'd1;
          end
        end
      end
      IFG: begin
        if (ifg_q <= IFG_1) begin
          ifg_d   = '0;
          state_d = IDLE;
        end else begin
          ifg_d = ifg_q - IFG_1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk20 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      byte_q  <= '0;
      cyc_q   <= '0;
      ifg_q   <= IFG_L;
      crc_q   <= '1;
      rr_q    <= 1'b0;
      sel_q   <= 1'b0;
      sp_q    <= 1'b0;
      fl_q    <= 1'b0;
      busy_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      byte_q  <= byte_d;
      cyc_q   <= cyc_d;
      ifg_q   <= ifg_d;
      crc_q   <= crc_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      sp_q    <= sp_d;
      fl_q    <= fl_d;
      busy_q  <= busy_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err_q   <= err_d;
    end
  end

  assign buf_sel       = sel_q;
  assign SendingPacket = sp_q;
  assign CRCflush      = fl_q;
  assign CRC           = fl_q & ~crc_q[31];
  assign busy          = busy_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_tenbaset_tx_ctrl.sv
// Scoreboard bench for tenbaset_tx_ctrl: random frames, FCS model,
// arbitration model, length reject, padding and mid-frame reset.
module tb_tenbaset_tx_ctrl;

  localparam int IFG = 192;
  localparam int MINL = 68;
  localparam int MAXL = 1522;

  logic       clk20 = 1'b0;
  logic       rst_n;
  logic [3:0] sc;
  logic [10:0] addr;
  logic       tx_bit;
  logic       buf_sel, SendingPacket, CRCflush, CRC, busy;

  tenbaset_tx_ctrl_if bus ();

  tenbaset_tx_ctrl #(
    .IFG_CYCLES (IFG),
    .MIN_LEN    (MINL),
    .MAX_LEN    (MAXL)
  ) dut (
    .clk20         (clk20),
    .rst_n         (rst_n),
    .bus           (bus),
    .ShiftCount    (sc),
    .tx_bit        (tx_bit),
    .buf_sel       (buf_sel),
    .SendingPacket (SendingPacket),
    .CRCflush      (CRCflush),
    .CRC           (CRC),
    .busy          (busy)
  );

  always #25 clk20 = ~clk20;

  logic [7:0] ram [2][2048];

  // Transmitter model: 16 clocks per byte, bit (sc>>1) of current byte
  always @(posedge clk20 or negedge rst_n) begin
    if (!rst_n) begin
      sc   <= '0;
      addr <= '0;
    end else if (!SendingPacket) begin
      sc   <= '0;
      addr <= '0;
    end else begin
      sc <= sc + 4'd1;
      if (sc == 4'd15) addr <= addr + 11'd1;
    end
  end

  assign tx_bit = ram[buf_sel][addr][sc[3:1]];

  typedef struct {
    int          id;
    bit          err;
    int          len;
    logic [31:0] fcs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   last = 1;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Standard reflected CRC-32 over the bytes after preamble/SFD
  function automatic logic [31:0] ref_fcs(int id, int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 8; i < n; i++) begin
      c ^= {24'd0, ram[id][i]};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic int tie_winner();
`ifdef TENBASET_TX_FIXED_PRIO_EN
    return 0;
`else
    return (last == 0) ? 1 : 0;
`endif
  endfunction

  task automatic prep(input int id, input bit zero);
    for (int i = 0; i < 7; i++) ram[id][i] = 8'h55;
    ram[id][7] = 8'hD5;
    for (int i = 8; i < 2048; i++)
      ram[id][i] = zero ? 8'h00 : 8'($urandom);
  endtask

  task automatic push_exp(input int id, input int len);
    exp_t e;
    e.id  = id;
    e.err = (len > MAXL);
    e.len = (len < MINL) ? MINL : len;
    e.fcs = e.err ? 32'h0 : ref_fcs(id, e.len);
    exp_q.push_back(e);
    last = id;
  endtask

  task automatic set_req(input int id, input bit v);
    if (id == 0) bus.req0 = v;
    else         bus.req1 = v;
  endtask

  task automatic set_len(input int id, input int len);
    if (id == 0) bus.len0 = 11'(len);
    else         bus.len1 = 11'(len);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.req0 || bus.req1)
           && t < 20000) begin
      @(negedge clk20);
      t++;
      if (bus.done0) bus.req0 = 1'b0;
      if (bus.done1) bus.req1 = 1'b0;
    end
    if (t >= 20000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d items left", exp_q.size());
      exp_q.delete();
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
    end
  endtask

  task automatic run_one(input int id, input int len,
                         input bit drop_mid);
    int t = 0;
    bit seen = 0;
    set_len(id, len);
    push_exp(id, len);
    set_req(id, 1'b1);
    while (!seen && t < 5000) begin
      @(negedge clk20);
      t++;
      if (bus.done0 || bus.done1) begin
        if (bus.done0) bus.req0 = 1'b0;
        if (bus.done1) bus.req1 = 1'b0;
        seen = 1;
      end else if (SendingPacket) begin
        seen = 1;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_timeout: req%0d len %0d", id, len);
    end else if (SendingPacket) begin
      // length sampled only at grant; req drop mid-frame ignored
      set_len(id, int'($urandom_range(0, 2047)));
      if (drop_mid) begin
        repeat ($urandom_range(1, 200)) @(negedge clk20);
        set_req(id, 1'b0);
      end
    end
    wait_drain();
  endtask

  // Monitor: captures each frame and pops the scoreboard on done/err
  bit          in_frame = 0;
  bit          ifg_on = 0;
  bit          sel_cap, sel_bad;
  int          sp_cnt, fl_cnt, fl_start, nbits, ifg_cnt;
  logic [31:0] fcs_rx;

  always @(negedge clk20) begin
    exp_t e;
    if (!rst_n) begin
      in_frame = 0;
      ifg_on   = 0;
    end else begin
      if (SendingPacket) begin
        if (!in_frame) begin
          in_frame = 1;
          sp_cnt   = 0;
          fl_cnt   = 0;
          fl_start = 0;
          nbits    = 0;
          sel_cap  = buf_sel;
          sel_bad  = 0;
        end
        sp_cnt++;
        if (buf_sel !== sel_cap) sel_bad = 1;
        if (CRCflush) begin
          fl_cnt++;
          if (fl_start == 0) fl_start = sp_cnt;
          if (sc[0]) begin
            if (nbits < 32) fcs_rx[nbits] = CRC;
            nbits++;
          end
        end
      end
      if (bus.done0 || bus.done1 || bus.err) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: d0 %0b d1 %0b err %0b",
                   bus.done0, bus.done1, bus.err);
        end else begin
          e = exp_q.pop_front();
          check("done_id", bus.done1, e.id);
          check("done_single", bus.done0 & bus.done1, 0);
          check("err_flag", bus.err, e.err);
          if (e.err) begin
            check("rej_no_tx", in_frame, 0);
            check("rej_busy", busy, 0);
          end else begin
            check("frame_seen", in_frame, 1);
            check("sp_at_done", SendingPacket, 0);
            check("sp_cycles", sp_cnt, e.len * 16 + 64);
            check("flush_cycles", fl_cnt, 64);
            check("flush_start", fl_start, e.len * 16 + 1);
            check("crc_bits", nbits, 32);
            check("fcs", fcs_rx, e.fcs);
            check("buf_sel", sel_cap, e.id);
            check("buf_sel_stable", sel_bad, 0);
            ifg_on  = 1;
            ifg_cnt = 0;
          end
        end
        in_frame = 0;
      end else if (in_frame && !SendingPacket) begin
        n_checks++;
        n_fail++;
        $display("FAIL no_done: frame ended after %0d cycles",
                 sp_cnt);
        in_frame = 0;
      end
      if (ifg_on) begin
        if (busy) begin
          ifg_cnt++;
        end else begin
          check("ifg_cycles", ifg_cnt, IFG);
          ifg_on = 0;
        end
      end
    end
  end

  initial begin
    #(50 * 90000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, lw0, lw1, cnt, id, len;
    rst_n    = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.len0 = '0;
    bus.len1 = '0;
    prep(0, 0);
    prep(1, 0);
    repeat (3) @(negedge clk20);
    check("rst_sp", SendingPacket, 0);
    check("rst_flush", CRCflush, 0);
    check("rst_crc", CRC, 0);
    check("rst_done0", bus.done0, 0);
    check("rst_done1", bus.done1, 0);
    check("rst_err", bus.err, 0);
    check("rst_buf_sel", buf_sel, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // minimum frame, all-zero payload
    prep(0, 1);
    run_one(0, 68, 0);
    // short frame gets padded
    prep(0, 0);
    run_one(0, 20, 0);
    // oversize frame rejected
    prep(1, 0);
    run_one(1, 1600, 0);

    // simultaneous requests, two rounds
    for (int r = 0; r < 2; r++) begin
      prep(0, 0);
      prep(1, 0);
      lw0 = int'($urandom_range(60, 80));
      lw1 = int'($urandom_range(60, 80));
      set_len(0, lw0);
      set_len(1, lw1);
      w = tie_winner();
      push_exp(w, (w == 0) ? lw0 : lw1);
      push_exp(1 - w, (w == 0) ? lw1 : lw0);
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      wait_drain();
    end

    // random frames
    for (int k = 0; k < 6; k++) begin
      id  = int'($urandom_range(0, 1));
      len = ($urandom_range(0, 4) == 0)
          ? int'($urandom_range(1523, 2047))
          : int'($urandom_range(1, 130));
      prep(id, 0);
      run_one(id, len, 1'($urandom_range(0, 1)));
    end

    // reset 500 cycles into SEND
    prep(0, 0);
    set_len(0, 100);
    bus.req0 = 1'b1;
    cnt = 0;
    while (!SendingPacket && cnt < 2000) begin
      @(negedge clk20);
      cnt++;
    end
    check("abort_started", SendingPacket, 1);
    repeat (500) @(negedge clk20);
    #10 rst_n = 1'b0;
    #1;
    check("abort_sp", SendingPacket, 0);
    check("abort_flush", CRCflush, 0);
    check("abort_busy", busy, 0);
    check("abort_done0", bus.done0, 0);
    last = 1;
    @(negedge clk20);
    @(negedge clk20);
    push_exp(0, 100);
    rst_n = 1'b1;
    cnt = 0;
    while (!SendingPacket && cnt < 400) begin
      @(negedge clk20);
      cnt++;
    end
    check("restart_delay_ok", (cnt > IFG && cnt <= IFG + 8), 1);
    wait_drain();
    repeat (IFG + 10) @(negedge clk20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
